// File: rtl/router_ctrl.sv
// router_ctrl: control FSM for the 1-input / 3-output packet router.
// Steers header, payload and parity bytes into a destination FIFO, checks parity and watches for unread FIFOs.
module router_ctrl #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 30,
    parameter int DATA_W    = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic                 busy,
    output logic                 error,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 lfd,
    output logic [NUM_PORTS-1:0] valid_out,
    output logic [NUM_PORTS-1:0] soft_reset
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_DECODE          = 3'd0,
        ST_DROP            = 3'd1,
        ST_WAIT_EMPTY      = 3'd2,
        ST_LFD             = 3'd3,
        ST_LOAD_DATA       = 3'd4,
        ST_FIFO_FULL       = 3'd5,
        ST_LOAD_AFTER_FULL = 3'd6,
        ST_CHECK_PARITY    = 3'd7
    } state_e;

    state_e                           state_q, state_d;
    logic [1:0]                       addr_q, addr_d;
    logic [DATA_W-1:0]                par_q, par_d;
    logic [DATA_W-1:0]                rx_par_q, rx_par_d;
    logic [DATA_W-1:0]                hold_q, hold_d;
    logic                             hold_pv_q, hold_pv_d;
    logic                             err_q, err_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]             sr_q, sr_d;
    logic                             wr_go_s;
    logic                             hdr_legal_s;
    logic                             full_cur_s;
    logic                             empty_cur_s;
    logic                             sr_cur_s;

    // Selects one per-port bit by a 2-bit address; out-of-range addresses read as 0.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec, input logic [1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r = (a == 2'(i)) ? vec[i] : r;
        end
        return r;
    endfunction

    assign hdr_legal_s = (int'(data_in[1:0]) < NUM_PORTS);
    assign full_cur_s  = port_bit(fifo_full, addr_q);
    assign empty_cur_s = port_bit(fifo_empty, addr_q);
    assign sr_cur_s    = port_bit(sr_q, addr_q);
    assign valid_out   = ~fifo_empty;
    assign error       = err_q;
    assign soft_reset  = sr_q;

    // Next-state and Mealy output decode; a flush of the active port aborts the packet.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        par_d     = par_q;
        rx_par_d  = rx_par_q;
        hold_d    = hold_q;
        hold_pv_d = hold_pv_q;
        err_d     = err_q;
        busy      = 1'b0;
        lfd       = 1'b0;
        wr_go_s   = 1'b0;
        wr_data   = data_in;
        case (state_q)
            ST_DECODE: begin
                if (pkt_valid) begin
                    addr_d = data_in[1:0];
                    if (!hdr_legal_s) begin
                        state_d = ST_DROP;
                    end else if (port_bit(fifo_empty, data_in[1:0])) begin
                        state_d = ST_LFD;
                    end else begin
                        state_d = ST_WAIT_EMPTY;
                    end
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DROP: begin
                if (!pkt_valid) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_WAIT_EMPTY: begin
                busy = 1'b1;
                if (sr_cur_s) begin
                    state_d = ST_DECODE;
                end else if (empty_cur_s) begin
                    state_d = ST_LFD;
                end else begin
                    state_d = ST_WAIT_EMPTY;
                end
            end
            ST_LFD: begin
                busy = 1'b1;
                if (sr_cur_s) begin
                    state_d = ST_DECODE;
                end else if (full_cur_s) begin
                    state_d = ST_LFD;
                end else begin
                    wr_go_s = 1'b1;
                    lfd     = 1'b1;
                    par_d   = data_in;
                    err_d   = 1'b0;
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                if (sr_cur_s) begin
                    state_d = ST_DECODE;
                end else if (full_cur_s) begin
                    // The source moves on this cycle, so park its byte until space frees up.
                    hold_d    = data_in;
                    hold_pv_d = pkt_valid;
                    state_d   = ST_FIFO_FULL;
                end else if (pkt_valid) begin
                    wr_go_s = 1'b1;
                    par_d   = par_q ^ data_in;
                end else begin
                    wr_go_s  = 1'b1;
                    rx_par_d = data_in;
                    state_d  = ST_CHECK_PARITY;
                end
            end
            ST_FIFO_FULL: begin
                busy = 1'b1;
                if (sr_cur_s) begin
                    state_d = ST_DECODE;
                end else if (!full_cur_s) begin
                    state_d = ST_LOAD_AFTER_FULL;
                end else begin
                    state_d = ST_FIFO_FULL;
                end
            end
            ST_LOAD_AFTER_FULL: begin
                busy    = 1'b1;
                wr_data = hold_q;
                if (sr_cur_s) begin
                    state_d = ST_DECODE;
                end else if (full_cur_s) begin
                    state_d = ST_LOAD_AFTER_FULL;
                end else if (hold_pv_q) begin
                    wr_go_s = 1'b1;
                    par_d   = par_q ^ hold_q;
                    state_d = ST_LOAD_DATA;
                end else begin
                    wr_go_s  = 1'b1;
                    rx_par_d = hold_q;
                    state_d  = ST_CHECK_PARITY;
                end
            end
            ST_CHECK_PARITY: begin
                busy    = 1'b1;
                err_d   = (par_q != rx_par_q);
                state_d = ST_DECODE;
            end
            default: begin
                state_d = ST_DECODE;
            end
        endcase
    end

    // One-hot write strobe towards the latched destination.
    always_comb begin
        write_enb = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            write_enb[i] = wr_go_s && (addr_q == 2'(i));
        end
    end

    // Per-port read watchdog: count unread non-empty cycles, pulse a flush on the last one.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (read_enb[i] || fifo_empty[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                cnt_d[i] = {CNT_W{1'b0}};
                sr_d[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State, datapath and watchdog registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_DECODE;
            addr_q    <= 2'd0;
            par_q     <= {DATA_W{1'b0}};
            rx_par_q  <= {DATA_W{1'b0}};
            hold_q    <= {DATA_W{1'b0}};
            hold_pv_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= {(NUM_PORTS*CNT_W){1'b0}};
            sr_q      <= {NUM_PORTS{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            par_q     <= par_d;
            rx_par_q  <= rx_par_d;
            hold_q    <= hold_d;
            hold_pv_q <= hold_pv_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed and randomized packets against a packet-level scoreboard,
// parity model and run-length watchdog model.
module tb_router_ctrl;

    localparam int NP = 3;
    localparam int TO = 30;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [7:0]    data_in;
    logic [NP-1:0] fifo_full;
    logic [NP-1:0] fifo_empty;
    logic [NP-1:0] read_enb;
    logic          busy;
    logic          error;
    logic [NP-1:0] write_enb;
    logic [7:0]    wr_data;
    logic          lfd;
    logic [NP-1:0] valid_out;
    logic [NP-1:0] soft_reset;

    int            checks = 0;
    int            errors = 0;
    int            run_len [NP];
    logic [NP-1:0] exp_sr = '0;
    logic          err_model = 1'b0;

    router_ctrl #(.NUM_PORTS(NP), .TIMEOUT(TO), .DATA_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .error      (error),
        .write_enb  (write_enb),
        .wr_data    (wr_data),
        .lfd        (lfd),
        .valid_out  (valid_out),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; the watchdog expectation is every TO-th cycle of an unbroken unread run.
    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < NP; i++) begin
            if (!resetn || fifo_empty[i] || read_enb[i]) run_len[i] = 0;
            else run_len[i]++;
            exp_sr[i] = (run_len[i] > 0) && (run_len[i] % TO == 0);
        end
        #1;
        check_eq("soft_reset", soft_reset, exp_sr);
    endtask

    task automatic set_env(input bit rnd);
        if (!rnd) begin
            fifo_full  = '0;
            fifo_empty = '1;
            read_enb   = '1;
        end else begin
            for (int i = 0; i < NP; i++) begin
                fifo_empty[i] = ($urandom_range(0, 2) == 0);
                fifo_full[i]  = !fifo_empty[i] && ($urandom_range(0, 3) == 0);
                read_enb[i]   = ($urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic drive(input logic pv, input logic [7:0] d);
        pkt_valid = pv;
        data_in   = d;
    endtask

    task automatic expect_out(input string tag, input logic [NP-1:0] we, input logic bsy, input logic lf);
        check_eq({tag, "_we"}, write_enb, we);
        check_eq({tag, "_busy"}, busy, bsy);
        check_eq({tag, "_lfd"}, lfd, lf);
    endtask

    // Sends one packet with a source that holds the header until written and otherwise moves on !busy.
    task automatic run_packet(input logic [1:0] addr, input int len, input bit bad_par,
                              input bit rnd, output int n_wr, output int n_busy);
        logic [7:0]    bytes[$];
        logic [7:0]    exp_q[$];
        logic [7:0]    par;
        logic [NP-1:0] exp_vo;
        int            idx;
        bit            legal, adv, err_pending, done;
        legal = (int'(addr) < NP);
        bytes.push_back({len[5:0], addr});
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
        par = 8'h00;
        foreach (bytes[i]) par = par ^ bytes[i];
        bytes.push_back(bad_par ? (par ^ 8'h01) : par);
        if (legal) exp_q = bytes;
        idx = 0; n_wr = 0; n_busy = 0; err_pending = 0; done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (idx < bytes.size()) drive(idx < bytes.size() - 1, bytes[idx]);
            else drive(1'b0, 8'($urandom));
            set_env(rnd);
            #1;
            exp_vo = ~fifo_empty;
            check_eq("valid_out", valid_out, exp_vo);
            if (err_pending) check_eq("err_clr", error, 1'b0);
            err_pending = 0;
            if (busy) n_busy++;
            if (!legal) begin
                check_eq("drop_nowr", write_enb, 0);
                check_eq("drop_lfd", lfd, 1'b0);
            end else if (write_enb != 0) begin
                n_wr++;
                check_eq("wr_port", write_enb, 32'd1 << addr);
                check_eq("wr_notfull", fifo_full & write_enb, 0);
                if (exp_q.size() == 0) begin
                    check_eq("extra_wr", write_enb, 0);
                end else begin
                    check_eq("lfd", lfd, exp_q.size() == bytes.size());
                    err_pending = lfd;
                    check_eq("wr_data", wr_data, exp_q.pop_front());
                end
            end else begin
                check_eq("lfd_idle", lfd, 1'b0);
            end
            adv = (idx == 0) ? (legal ? (write_enb != 0) : 1'b1) : !busy;
            tick();
            if (adv && idx < bytes.size()) idx++;
            done = (idx >= bytes.size()) && (exp_q.size() == 0);
        end
        check_eq("pkt_progress", exp_q.size() + (bytes.size() - idx), 0);
        drive(1'b0, 8'h00);
        set_env(rnd);
        if (legal) begin
            #1;
            check_eq("chk_busy", busy, 1'b1);
            if (busy) n_busy++;
            tick();
            err_model = bad_par;
        end
        #1;
        check_eq("pkt_error", error, err_model);
        check_eq("idle_busy", busy, 1'b0);
        tick();
    endtask

    initial begin
        int nw, nb, len;
        logic [1:0] addr;
        bit bad;
        for (int i = 0; i < NP; i++) run_len[i] = 0;
        resetn = 1'b0;
        drive(1'b0, 8'h00);
        set_env(1'b0);
        #1;
        expect_out("reset", 3'b000, 1'b0, 1'b0);
        check_eq("reset_err", error, 1'b0);
        check_eq("reset_sr", soft_reset, 3'b000);
        tick();
        resetn = 1'b1;
        tick();

        run_packet(2'd0, 5, 1'b0, 1'b0, nw, nb);
        check_eq("d1_writes", nw, 7);
        check_eq("d1_busy", nb, 2);
        run_packet(2'd0, 5, 1'b1, 1'b0, nw, nb);
        check_eq("d2_error", error, 1'b1);
        run_packet(2'd0, 5, 1'b0, 1'b0, nw, nb);
        run_packet(2'd0, 3, 1'b1, 1'b0, nw, nb);
        run_packet(2'd3, 4, 1'b0, 1'b0, nw, nb);

        // Drop packet interrupted by reset while error is still set.
        drive(1'b1, 8'h13);
        #1; expect_out("rst_dec", 3'b000, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hA5);
        #1; expect_out("rst_drop", 3'b000, 1'b0, 1'b0);
        check_eq("rst_err_pre", error, 1'b1);
        resetn = 1'b0;
        #1;
        expect_out("rst_now", 3'b000, 1'b0, 1'b0);
        check_eq("rst_err", error, 1'b0);
        err_model = 1'b0;
        tick();
        drive(1'b0, 8'h00);
        resetn = 1'b1;
        tick();

        // Legal packet interrupted by reset mid-payload.
        drive(1'b1, 8'h04);
        #1; expect_out("rst2_dec", 3'b000, 1'b0, 1'b0); tick();
        #1; expect_out("rst2_lfd", 3'b001, 1'b1, 1'b1); tick();
        drive(1'b1, 8'h55);
        #1; expect_out("rst2_pay", 3'b001, 1'b0, 1'b0);
        resetn = 1'b0;
        #1; expect_out("rst2_now", 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00);
        resetn = 1'b1;
        tick();
        run_packet(2'd1, 2, 1'b0, 1'b0, nw, nb);
        check_eq("after_rst_writes", nw, 4);

        // Destination 2 busy: wait for it to drain.
        drive(1'b1, 8'h06);
        fifo_empty = 3'b011;
        #1; expect_out("we_dec", 3'b000, 1'b0, 1'b0); tick();
        for (int k = 0; k < 2; k++) begin
            #1; expect_out("we_wait", 3'b000, 1'b1, 1'b0); tick();
        end
        fifo_empty = 3'b111;
        #1; expect_out("we_rel", 3'b000, 1'b1, 1'b0); tick();
        #1; expect_out("we_lfd", 3'b100, 1'b1, 1'b1);
        check_eq("we_hdr", wr_data, 8'h06); tick();
        drive(1'b1, 8'h77);
        #1; expect_out("we_pay", 3'b100, 1'b0, 1'b0);
        check_eq("we_pay_d", wr_data, 8'h77); tick();
        drive(1'b0, 8'h71);
        #1; expect_out("we_par", 3'b100, 1'b0, 1'b0);
        check_eq("we_par_d", wr_data, 8'h71); tick();
        drive(1'b0, 8'h00);
        #1; expect_out("we_chk", 3'b000, 1'b1, 1'b0); tick();
        #1; expect_out("we_idle", 3'b000, 1'b0, 1'b0);
        check_eq("we_err", error, 1'b0); tick();

        // FIFO1 fills on payload byte 0x5A.
        drive(1'b1, 8'h09);
        #1; expect_out("ff_dec", 3'b000, 1'b0, 1'b0); tick();
        #1; expect_out("ff_lfd", 3'b010, 1'b1, 1'b1); tick();
        drive(1'b1, 8'h33);
        #1; expect_out("ff_p0", 3'b010, 1'b0, 1'b0);
        check_eq("ff_p0_d", wr_data, 8'h33); tick();
        drive(1'b1, 8'h5A);
        fifo_full = 3'b010;
        #1; expect_out("ff_full", 3'b000, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h60);
        #1; expect_out("ff_stall", 3'b000, 1'b1, 1'b0); tick();
        fifo_full = 3'b000;
        #1; expect_out("ff_rel", 3'b000, 1'b1, 1'b0); tick();
        #1; expect_out("ff_laf", 3'b010, 1'b1, 1'b0);
        check_eq("ff_laf_d", wr_data, 8'h5A); tick();
        #1; expect_out("ff_par", 3'b010, 1'b0, 1'b0);
        check_eq("ff_par_d", wr_data, 8'h60); tick();
        drive(1'b0, 8'h00);
        #1; expect_out("ff_chk", 3'b000, 1'b1, 1'b0); tick();
        #1; check_eq("ff_err", error, 1'b0); tick();

        // Watchdog on port 0: pulse after 30 unread cycles, and a read at cycle 29 restarts the count.
        fifo_empty = 3'b110;
        read_enb   = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check_eq("wd_pulse", soft_reset[0], k == 30);
        end
        read_enb = 3'b001;
        tick();
        for (int k = 1; k <= 60; k++) begin
            read_enb = (k == 29) ? 3'b001 : 3'b000;
            tick();
            check_eq("wd_restart", soft_reset[0], k == 59);
        end
        set_env(1'b0);
        tick();

        for (int p = 0; p < 60; p++) begin
            addr = 2'($urandom_range(0, 3));
            len  = $urandom_range(0, 8);
            bad  = ($urandom_range(0, 1) == 1);
            run_packet(addr, len, bad, 1'b1, nw, nb);
            if (addr != 2'd3) check_eq("rnd_nwr", nw, len + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
Control FSM for the 1-input, 3-output packet router. It decodes the header address and steers writes into one of three destination FIFOs. It throttles the source with busy and computes and checks packet parity. It also runs a per-port read-timeout watchdog that soft-resets any FIFO left unread for TIMEOUT cycles. It sits between the source interface (pkt_valid/data_in/busy/error) and the three FIFOs plus the destination readers.

Parameters:
NUM_PORTS, 3, number of destination FIFOs; address values 0..NUM_PORTS-1 are legal.
TIMEOUT, 30, consecutive unread cycles before soft_reset fires.
DATA_W, 8, byte width.

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  high on header and payload bytes; low on the parity byte cycle
data_in  in  DATA_W  packet byte; header[1:0]=dest addr, header[7:2]=length (informational only)
fifo_full  in  NUM_PORTS  per-FIFO full
fifo_empty  in  NUM_PORTS  per-FIFO empty
read_enb  in  NUM_PORTS  per-port destination read enable
busy  out  1  source must hold pkt_valid/data_in stable while high
error  out  1  parity mismatch on last packet
write_enb  out  NUM_PORTS  one-hot FIFO write strobe
wr_data  out  DATA_W  byte to write: data_in, or the hold register in LOAD_AFTER_FULL
lfd  out  1  current write is a header byte
valid_out  out  NUM_PORTS  = ~fifo_empty, combinational
soft_reset  out  NUM_PORTS  one-cycle FIFO flush pulse

Behaviour:
- Reset (resetn=0, async): state=DECODE; addr_q, parity_acc, hold_q, counters = 0; busy=0, error=0, write_enb=0, soft_reset=0, lfd=0.
- write_enb, lfd, busy and wr_data are decoded from state plus inputs (Moore/Mealy, no added latency). error and soft_reset are registered.
- DECODE (busy=0): on pkt_valid, latch addr_q=data_in[1:0].
  - addr==3 -> DROP.
  - fifo_empty[addr] -> LFD.
  - otherwise -> WAIT_EMPTY.
  - The header byte is held by the source; busy rises in the next state.
- DROP (busy=0, no writes): -> DECODE on the cycle pkt_valid=0 (parity byte is discarded).
- WAIT_EMPTY (busy=1): -> LFD when fifo_empty[addr_q].
- LFD (busy=1): write_enb[addr_q]=1, lfd=1, wr_data=data_in; parity_acc=data_in; error cleared -> LOAD_DATA.
- LOAD_DATA (busy=0):
  - fifo_full[addr_q]: no write; hold_q=data_in, hold_pv=pkt_valid -> FIFO_FULL.
  - pkt_valid: write data_in; parity_acc^=data_in; stay.
  - !pkt_valid: write the parity byte; rx_par=data_in -> CHECK_PARITY.
- FIFO_FULL (busy=1, no write): -> LOAD_AFTER_FULL when !fifo_full[addr_q].
- LOAD_AFTER_FULL (busy=1): write hold_q.
  - hold_pv=1: parity_acc^=hold_q -> LOAD_DATA.
  - hold_pv=0: rx_par=hold_q -> CHECK_PARITY.
- CHECK_PARITY (busy=1): error<=(parity_acc!=rx_par) on the next edge; error stays until the next LFD or reset -> DECODE.
- Watchdog, per port i:
  - cnt_i increments when valid_out[i] & !read_enb[i].
  - cnt_i clears on read_enb[i] or fifo_empty[i].
  - When cnt_i==TIMEOUT-1 and the increment condition holds: soft_reset[i]=1 for one cycle; cnt_i=0.
- Soft reset mid-packet: soft_reset[addr_q] in LFD/LOAD_DATA/FIFO_FULL/LOAD_AFTER_FULL/WAIT_EMPTY -> DECODE next cycle. No write on that cycle; error unchanged.
- Simultaneous full and !pkt_valid in LOAD_DATA: full takes priority; the parity byte goes via the hold path.
- Only one write_enb bit is ever high. No write ever occurs to a port whose fifo_full is high.

Test Plan:
- Header 0x14 (addr0, len5), 5 payload bytes, correct parity, FIFO0 empty -> write_enb[0] for 7 cycles with lfd on the first; busy high in LFD and CHECK_PARITY only; error=0.
- Same packet with the parity byte XOR 0x01 -> error=1 from the cycle after CHECK_PARITY; error=0 again on the next LFD.
- Header addr2 with fifo_empty[2]=0 -> WAIT_EMPTY, busy=1, no writes; release empty -> LFD next cycle.
- fifo_full[1] asserted mid-payload on byte 0x5A -> no write, busy=1; deassert full -> 0x5A written exactly once, then writes resume.
- valid_out[0]=1 with read_enb[0]=0 for 30 cycles -> soft_reset[0] pulses on cycle 30. A read_enb at cycle 29 -> no pulse, counter restarts.
- Header addr=3 -> no write_enb for the whole packet; return to DECODE, then the next addr1 packet is accepted. Also: resetn low mid-payload -> all outputs 0 immediately, state DECODE.
